// File: rtl/render_pkg.sv
// Shared types and constants for the render pipeline front end.
package render_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int HCOUNT_W       = 11;
    localparam int VCOUNT_W       = 10;
    // Depth of full_renderer's pipeline; pipe stages there are sized from this.
    localparam int RENDER_LATENCY = 339;

endpackage

// File: rtl/credit_counter.sv
// Up/down counter of outstanding items, saturating at 0 and at MAX.
// A decrement at zero is a protocol error from the consumer side.
module credit_counter #(
    parameter int MAX = 512,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: +1 on inc alone, -1 on dec alone, hold when both or neither.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_C)) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == MAX_C);

`ifndef SYNTHESIS
    // Flag a return arriving when nothing is outstanding.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dec && (count_q == '0)))
                else $error("credit_counter: decrement while count is zero");
        end
    end
`endif

endmodule

// File: rtl/render_scheduler.sv
// Frame sequencer: walks every pixel of the frame, issuing (hcount, vcount)
// beats under credit-based flow control, then drains in-flight pixels.
import render_pkg::*;

module render_scheduler #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 180,
    parameter int CREDITS  = 512
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         start,
    input  logic                         abort,
    output logic [HCOUNT_W-1:0]          hcount_axis_tdata,
    output logic [VCOUNT_W-1:0]          vcount_axis_tdata,
    output logic                         hv_axis_tvalid,
    input  logic                         hv_axis_tready,
    input  logic                         ret_valid,
    input  logic                         ret_ready,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         aborted,
    output logic [$clog2(CREDITS+1)-1:0] outstanding
);

    localparam int OUT_W = $clog2(CREDITS + 1);
    localparam int RET_W = $clog2(H_ACTIVE * V_ACTIVE + 1);

    localparam logic [HCOUNT_W-1:0] H_LAST    = HCOUNT_W'(H_ACTIVE - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST    = VCOUNT_W'(V_ACTIVE - 1);
    localparam logic [RET_W-1:0]    FRAME_PIX = RET_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [OUT_W-1:0]    ONE_OUT   = OUT_W'(1);

    sched_state_t         state_q,     state_d;
    logic [HCOUNT_W-1:0]  hCount_q,    hCount_d;
    logic [VCOUNT_W-1:0]  vCount_q,    vCount_d;
    logic                 abortFlag_q, abortFlag_d;
    logic [RET_W-1:0]     returned_q,  returned_d;
    logic                 frameDone_q, frameDone_d;
    logic                 aborted_q,   aborted_d;

    logic issue;
    logic ret;
    logic creditsFull;
    logic lastPixel;
    logic drainDone;

    assign hv_axis_tvalid = (state_q == ISSUE) && !creditsFull;
    assign issue          = hv_axis_tvalid && hv_axis_tready;
    assign ret            = ret_valid && ret_ready;
    assign lastPixel      = (hCount_q == H_LAST) && (vCount_q == V_LAST);
    // A return in this cycle counts towards emptying the pipeline.
    assign drainDone      = (outstanding == '0) || ((outstanding == ONE_OUT) && ret);

    credit_counter #(
        .MAX (CREDITS),
        .W   (OUT_W)
    ) uCredits (
        .clk   (aclk),
        .rst   (areset),
        .inc   (issue),
        .dec   (ret),
        .count (outstanding),
        .full  (creditsFull)
    );

    // Next-state logic: scan counters advance per accepted beat, abort wins over start.
    always_comb begin
        state_d     = state_q;
        hCount_d    = hCount_q;
        vCount_d    = vCount_q;
        abortFlag_d = abortFlag_q;
        returned_d  = returned_q + RET_W'(ret);
        frameDone_d = 1'b0;
        aborted_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = ISSUE;
                    hCount_d    = '0;
                    vCount_d    = '0;
                    abortFlag_d = 1'b0;
                    returned_d  = '0;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (hCount_q == H_LAST) begin
                        hCount_d = '0;
                        vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + 1'b1;
                    end else begin
                        hCount_d = hCount_q + 1'b1;
                    end
                end
                if (abort) begin
                    state_d     = DRAIN;
                    abortFlag_d = 1'b1;
                end else if (issue && lastPixel) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    abortFlag_d = 1'b1;
                end
                if (drainDone) begin
                    state_d = IDLE;
                    if (abortFlag_q || abort) begin
                        aborted_d = 1'b1;
                    end else begin
                        frameDone_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, scan counters and completion pulses.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            hCount_q    <= '0;
            vCount_q    <= '0;
            abortFlag_q <= 1'b0;
            returned_q  <= '0;
            frameDone_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hCount_q    <= hCount_d;
            vCount_q    <= vCount_d;
            abortFlag_q <= abortFlag_d;
            returned_q  <= returned_d;
            frameDone_q <= frameDone_d;
            aborted_q   <= aborted_d;
        end
    end

    assign hcount_axis_tdata = hCount_q;
    assign vcount_axis_tdata = vCount_q;
    assign busy              = (state_q != IDLE);
    assign frame_done        = frameDone_q;
    assign aborted           = aborted_q;

`ifndef SYNTHESIS
    // A completed frame must have seen every pixel come back.
    always @(posedge aclk) begin
        if (!areset && frameDone_d) begin
            assert (returned_d == FRAME_PIX)
                else $error("render_scheduler: frame_done with %0d pixels returned", returned_d);
        end
    end
`endif

endmodule
